// File: rtl/convpress_decomp_d1_if.sv
// Bus bundle for the sparse-to-dense decompressor: the compressed beat
// stream in, the dense brick stream out, and the sticky error flag.
interface convpress_decomp_d1_if #(
    parameter int N         = 16,
    parameter int Tn        = 16,
    parameter int OFFSET_SZ = 4
);
    logic                 i_valid;
    logic                 o_ready;
    logic [N-1:0]         i_data;
    logic [OFFSET_SZ-1:0] i_idx;
    logic                 i_empty;
    logic                 i_last;
    logic                 o_valid;
    logic                 i_ready;
    logic [Tn*N-1:0]      o_data;
    logic [Tn-1:0]        o_mask;
    logic [OFFSET_SZ:0]   o_nnz;
    logic                 o_err;

    // Producer of compressed beats and consumer of dense bricks.
    modport master (
        output i_valid, i_data, i_idx, i_empty, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_mask, o_nnz, o_err
    );

    // The decompressor itself.
    modport slave (
        input  i_valid, i_data, i_idx, i_empty, i_last, i_ready,
        output o_ready, o_valid, o_data, o_mask, o_nnz, o_err
    );
endinterface

// File: rtl/convpress_decomp_d1.sv
// Sparse-to-dense decompressor. Collects (value, index) beats into a fill
// buffer and, on the last beat of a brick, hands the dense brick with its
// nonzero mask and count to a separate output register so the next brick
// can start filling while the current one waits on downstream.
module convpress_decomp_d1 #(
    parameter int N         = 16,
    parameter int Tn        = 16,
    parameter int OFFSET_SZ = 4
) (
    input logic                  clk,
    input logic                  rst,
    convpress_decomp_d1_if.slave bus
);
    localparam logic [OFFSET_SZ:0] IDX_LIMIT = (OFFSET_SZ+1)'(Tn);

    typedef enum logic {FILL, PEND} state_t;

    state_t               state;
    logic [N-1:0]         fill_val [Tn];
    logic [Tn-1:0]        fill_mask;
    logic [OFFSET_SZ:0]   fill_nnz;
    logic [OFFSET_SZ-1:0] prev_idx;
    logic                 first;

    logic [N-1:0]         next_val [Tn];
    logic [Tn-1:0]        next_mask;
    logic [OFFSET_SZ:0]   next_nnz;
    logic [Tn*N-1:0]      next_data;
    logic [Tn*N-1:0]      fill_data;

    logic accept;
    logic in_range;
    logic ordered;
    logic write;
    logic bad;
    logic out_free;

    // Beats are only taken while filling; PEND holds a finished brick.
    assign bus.o_ready = (state == FILL);
    assign accept      = bus.i_valid && bus.o_ready;
    assign in_range    = {1'b0, bus.i_idx} < IDX_LIMIT;
    assign ordered     = first || (bus.i_idx > prev_idx);
    assign write       = accept && !bus.i_empty && in_range && ordered;
    assign bad         = accept && !bus.i_empty && !(in_range && ordered);
    // The output slot can take a brick if empty or being drained this edge.
    assign out_free    = !bus.o_valid || bus.i_ready;

    // Fill buffer with the current beat merged in, so a last beat's own
    // value is part of the brick handed over at that same edge.
    always_comb begin
        next_data = '0;
        fill_data = '0;
        next_mask = fill_mask;
        for (int k = 0; k < Tn; k++) begin
            next_val[k] = fill_val[k];
            if (write && bus.i_idx == OFFSET_SZ'(k)) begin
                next_val[k]  = bus.i_data;
                next_mask[k] = 1'b1;
            end
            next_data[k*N +: N] = next_val[k];
            fill_data[k*N +: N] = fill_val[k];
        end
        next_nnz = fill_nnz + (OFFSET_SZ+1)'(write);
    end

    // Fill FSM, fill buffer, output brick register and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            for (int k = 0; k < Tn; k++) fill_val[k] <= '0;
            fill_mask <= '0;
            fill_nnz  <= '0;
            prev_idx  <= '0;
            first     <= 1'b1;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_mask  <= '0;
            bus.o_nnz   <= '0;
            bus.o_err   <= 1'b0;
        end else begin
            if (bad) bus.o_err <= 1'b1;
            // A handshake empties the slot; a transfer below may refill it.
            if (bus.o_valid && bus.i_ready) bus.o_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (bus.i_last && out_free) begin
                            bus.o_data  <= next_data;
                            bus.o_mask  <= next_mask;
                            bus.o_nnz   <= next_nnz;
                            bus.o_valid <= 1'b1;
                            for (int k = 0; k < Tn; k++) fill_val[k] <= '0;
                            fill_mask <= '0;
                            fill_nnz  <= '0;
                            prev_idx  <= '0;
                            first     <= 1'b1;
                        end else begin
                            for (int k = 0; k < Tn; k++) fill_val[k] <= next_val[k];
                            fill_mask <= next_mask;
                            fill_nnz  <= next_nnz;
                            if (write) begin
                                prev_idx <= bus.i_idx;
                                first    <= 1'b0;
                            end
                            if (bus.i_last) state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (out_free) begin
                        bus.o_data  <= fill_data;
                        bus.o_mask  <= fill_mask;
                        bus.o_nnz   <= fill_nnz;
                        bus.o_valid <= 1'b1;
                        for (int k = 0; k < Tn; k++) fill_val[k] <= '0;
                        fill_mask <= '0;
                        fill_nnz  <= '0;
                        prev_idx  <= '0;
                        first     <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
